// File: rtl/defuzz_cog.sv
// Centre-of-gravity defuzzifier: accumulates sum(mu*s) and sum(mu) per frame, then divides.
// Define DEFUZZ_COG_ROUND_EN to get rounding to nearest, with halves rounded away from zero.
module defuzz_cog #(
    parameter int MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mu,
    input  logic [7:0]  s,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  y,
    output logic        zero_w,
    output logic        err_ovf
);

`ifdef DEFUZZ_COG_ROUND_EN
    localparam int QB = 9;
`else
    localparam int QB = 8;
`endif
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

    state_t              r_state;
    logic signed [27:0]  r_num;
    logic [19:0]         r_den;
    logic [CNT_W-1:0]    r_cnt;
    logic [29:0]         r_rem;
    logic [29:0]         r_dvs;
    logic [QB-2:0]       r_q;
    logic                r_neg;
    logic [3:0]          r_step;
    logic [7:0]          r_y;
    logic                r_zero_w;
    logic                r_err_ovf;
    logic                r_in_ready;
    logic                r_out_valid;

    logic signed [24:0]  w_prod;
    logic signed [27:0]  w_num_nxt;
    logic [19:0]         w_den_nxt;
    logic                w_close;
    logic [27:0]         w_abs;
    logic [29:0]         w_rem_init;
    logic [29:0]         w_dvs_init;
    logic                w_ge;
    logic [QB-1:0]       w_q_nxt;

    // Rounded (or truncated) quotient magnitude; at most 128 for any legal frame.
    function automatic logic [8:0] round_mag(input logic [QB-1:0] q);
`ifdef DEFUZZ_COG_ROUND_EN
        logic [QB:0] t;
        t = {1'b0, q} + {{QB{1'b0}}, 1'b1};
        return t[QB:1];
`else
        return {1'b0, q};
`endif
    endfunction

    function automatic logic [7:0] sat_y(input logic neg, input logic [8:0] mag);
        if (neg)
            return (mag >= 9'd128) ? 8'h80 : 8'(~mag[7:0] + 8'd1);
        else
            return (mag > 9'd127) ? 8'h7f : mag[7:0];
    endfunction

    assign w_prod    = $signed({1'b0, mu}) * $signed(s);
    assign w_num_nxt = r_num + {{3{w_prod[24]}}, w_prod};
    assign w_den_nxt = r_den + {4'd0, mu};
    assign w_close   = in_last || (r_cnt == CNT_W'(MAX_TERMS - 1));
    assign w_abs     = w_num_nxt[27] ? $unsigned(-w_num_nxt) : $unsigned(w_num_nxt);
`ifdef DEFUZZ_COG_ROUND_EN
    assign w_rem_init = {1'b0, w_abs, 1'b0};
`else
    assign w_rem_init = {2'b00, w_abs};
`endif
    assign w_dvs_init = {10'd0, w_den_nxt} << (QB - 1);
    assign w_ge       = (r_rem >= r_dvs);
    assign w_q_nxt    = {r_q, w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_num       <= '0;
            r_den       <= '0;
            r_cnt       <= '0;
            r_step      <= '0;
            r_y         <= '0;
            r_zero_w    <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (in_valid && r_in_ready) begin
                        r_num <= w_num_nxt;
                        r_den <= w_den_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_close) begin
                            r_err_ovf  <= !in_last;
                            r_in_ready <= 1'b0;
                            if (w_den_nxt == 20'd0) begin
                                r_y         <= '0;
                                r_zero_w    <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_state     <= OUT;
                            end else begin
                                r_rem   <= w_rem_init;
                                r_dvs   <= w_dvs_init;
                                r_neg   <= w_num_nxt[27];
                                r_step  <= '0;
                                r_state <= DIV;
                            end
                        end
                    end
                end
                // One restoring-division quotient bit per cycle, MSB first.
                DIV: begin
                    if (w_ge)
                        r_rem <= r_rem - r_dvs;
                    r_dvs  <= r_dvs >> 1;
                    r_q    <= w_q_nxt[QB-2:0];
                    r_step <= r_step + 4'd1;
                    if (r_step == 4'(QB - 1)) begin
                        r_y         <= sat_y(r_neg, round_mag(w_q_nxt));
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_num       <= '0;
                        r_den       <= '0;
                        r_cnt       <= '0;
                        r_zero_w    <= 1'b0;
                        r_err_ovf   <= 1'b0;
                        r_state     <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero_w    = r_zero_w;
    assign err_ovf   = r_err_ovf;

endmodule
